// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, derived address-field widths and the FSM
// state encoding for the instruction cache (icache_fetch, icache_line_store).
package icache_pkg;

    localparam int LINE_WORDS_DEF = 4;
    localparam int NUM_LINES_DEF  = 8;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;

    // Word-offset field width within a line.
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width.
    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag is whatever remains of the word address above index and offset.
    function automatic int tag_w(input int line_words, input int num_lines);
        return ADDR_W - $clog2(line_words) - $clog2(num_lines);
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data storage of the direct-mapped icache.
// Ports:
//   clk, reset_n            clock, synchronous active-high reset (valid bits only)
//   rd_idx_i, rd_off_i      combinational read address
//   rd_valid_o, rd_tag_o,
//   rd_word_o               valid bit, tag and word of the addressed line
//   wr_en_i, wr_idx_i,
//   wr_off_i, wr_data_i     single word write into the data array
//   inst_en_i, inst_tag_i,
//   inst_valid_i            install tag/valid of line wr_idx_i
//   inval_i                 clear every valid bit
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int NUM_LINES  = NUM_LINES_DEF
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [idx_w(NUM_LINES)-1:0]             rd_idx_i,
    input  logic [off_w(LINE_WORDS)-1:0]            rd_off_i,
    output logic                                    rd_valid_o,
    output logic [tag_w(LINE_WORDS,NUM_LINES)-1:0]  rd_tag_o,
    output logic [DATA_W-1:0]                       rd_word_o,
    input  logic                                    wr_en_i,
    input  logic [idx_w(NUM_LINES)-1:0]             wr_idx_i,
    input  logic [off_w(LINE_WORDS)-1:0]            wr_off_i,
    input  logic [DATA_W-1:0]                       wr_data_i,
    input  logic                                    inst_en_i,
    input  logic [tag_w(LINE_WORDS,NUM_LINES)-1:0]  inst_tag_i,
    input  logic                                    inst_valid_i,
    input  logic                                    inval_i
);

    localparam int TAG = tag_w(LINE_WORDS, NUM_LINES);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG-1:0]       tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES*LINE_WORDS];

    // Install after the global clear so an install never resurrects a line
    // killed in the same cycle (the top already forces inst_valid_i low then).
    always_ff @(posedge clk) begin
        if (reset_n) begin
            valid_q <= '0;
        end else begin
            if (inval_i)
                valid_q <= '0;
            if (inst_en_i)
                valid_q[wr_idx_i] <= inst_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i)
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        if (inst_en_i)
            tag_q[wr_idx_i] <= inst_tag_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_word_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only instruction cache with line refill.
// Optional feature: hit/miss statistics counters, built when the macro
// ICACHE_STATS_EN is defined.
// Ports:
//   clk, reset_n          clock, synchronous active-high reset
//   readM1, address1      CPU fetch request and word address
//   data1, i_stall        fetched word (hit) / fetch not served
//   inval                 invalidate all lines
//   mem_req, mem_addr     refill beat request and its word address
//   mem_ack, mem_rdata    beat acknowledge and returned word
//   hit_count, miss_count statistics (ICACHE_STATS_EN only)
//
// state  | meaning
// IDLE   | lookup; hit served combinationally, miss latches line and refills
// REFILL | fetch LINE_WORDS beats in order, install line on last ack
module icache_fetch
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int NUM_LINES  = NUM_LINES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               readM1,
    input  logic [ADDR_W-1:0]  address1,
    output logic [DATA_W-1:0]  data1,
    output logic               i_stall,
    input  logic               inval,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    localparam int OFF = off_w(LINE_WORDS);
    localparam int IDX = idx_w(NUM_LINES);
    localparam int TAG = tag_w(LINE_WORDS, NUM_LINES);

    state_e           state_q, state_d;
    logic [OFF-1:0]   beat_q, beat_d;
    logic             kill_q, kill_d;
    logic [TAG-1:0]   ltag_q, ltag_d;
    logic [IDX-1:0]   lidx_q, lidx_d;

    logic [OFF-1:0]   a_off;
    logic [IDX-1:0]   a_idx;
    logic [TAG-1:0]   a_tag;
    logic             rd_valid;
    logic [TAG-1:0]   rd_tag;
    logic [DATA_W-1:0] rd_word;
    logic             hit;
    logic             wr_en, inst_en, inst_valid;

    assign a_off = address1[OFF-1:0];
    assign a_idx = address1[OFF+IDX-1:OFF];
    assign a_tag = address1[ADDR_W-1:OFF+IDX];

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        kill_d     = kill_q;
        ltag_d     = ltag_q;
        lidx_d     = lidx_q;
        data1      = '0;
        i_stall    = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        hit        = 1'b0;
        wr_en      = 1'b0;
        inst_en    = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hit = readM1 & rd_valid & (rd_tag == a_tag);
                if (hit) begin
                    data1 = rd_word;
                end else if (readM1) begin
                    i_stall = 1'b1;
                    ltag_d  = a_tag;
                    lidx_d  = a_idx;
                    beat_d  = '0;
                    kill_d  = 1'b0;
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {ltag_q, lidx_q, beat_q};
                i_stall  = 1'b1;
                if (inval)
                    kill_d = 1'b1;
                if (mem_ack) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == OFF'(LINE_WORDS - 1)) begin
                        inst_en = 1'b1;
                        // An inval on the final beat must also leave the line invalid.
                        inst_valid = ~(kill_q | inval);
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            kill_q  <= 1'b0;
            ltag_q  <= '0;
            lidx_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            kill_q  <= kill_d;
            ltag_q  <= ltag_d;
            lidx_q  <= lidx_d;
        end
    end

    icache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_store (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd_idx_i     (a_idx),
        .rd_off_i     (a_off),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_word_o    (rd_word),
        .wr_en_i      (wr_en & ~reset_n),
        .wr_idx_i     (lidx_q),
        .wr_off_i     (beat_q),
        .wr_data_i    (mem_rdata),
        .inst_en_i    (inst_en & ~reset_n),
        .inst_tag_i   (ltag_q),
        .inst_valid_i (inst_valid),
        .inval_i      (inval)
    );

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (state_q == ST_IDLE && state_d == ST_REFILL)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
